// File: rtl/isb_prefetcher.sv
// Irregular Stream Buffer prefetcher: PC-localised address correlation through
// physical->structural (PS) and structural->physical (SP) maps.
module isb_prefetcher #(
  parameter int PF_DEGREE = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        v_in,
  input  logic [15:0] pc,
  input  logic [15:0] addr,
  output logic        v_out,
  output logic [15:0] pf_addr
);

  typedef enum logic [1:0] {IDLE, WAIT, EMIT} state_t;
  state_t state, state_n;

  logic        tu_valid  [8];
  logic [12:0] tu_tag    [8];
  logic [15:0] tu_last   [8];
  logic        ps_valid  [64];
  logic [9:0]  ps_tag    [64];
  logic [15:0] ps_struct [64];
  logic        sp_valid  [64];
  logic [9:0]  sp_tag    [64];
  logic [15:0] sp_phys   [64];
  logic [15:0] alloc;

  logic [2:0]  tu_idx;
  logic        tu_hit, b_hit, train, a_hit, emit;
  logic [15:0] last_b, s_b, s_a, alloc_n, s_cur;
  logic [15:0] cand   [4];
  logic [15:0] cand_n [4];
  logic [3:0]  cand_v, cand_v_n;
  logic [1:0]  emit_idx;

  assign tu_idx = pc[2:0];

  // Training: resolve B's structural address (allocating a chunk if needed) and pick s_A.
  always_comb begin
    tu_hit  = tu_valid[tu_idx] && (tu_tag[tu_idx] == pc[15:3]);
    last_b  = tu_last[tu_idx];
    b_hit   = ps_valid[last_b[5:0]] && (ps_tag[last_b[5:0]] == last_b[15:6]);
    train   = v_in && tu_hit && (last_b != addr);
    s_b     = b_hit ? ps_struct[last_b[5:0]] : alloc;
    s_a     = s_b + 16'd1;
    alloc_n = alloc;
    if (!b_hit || (s_b[3:0] == 4'hF))
      alloc_n = alloc + 16'd16;
    if (b_hit && (s_b[3:0] == 4'hF))
      s_a = alloc;
  end

  // Prediction reads the maps before this access's writes; candidates never leave the chunk.
  always_comb begin : predict
    logic [15:0] s_k;
    s_k   = '0;
    a_hit = ps_valid[addr[5:0]] && (ps_tag[addr[5:0]] == addr[15:6]);
    s_cur = ps_struct[addr[5:0]];
    for (int k = 0; k < 4; k++) begin
      s_k         = s_cur + 16'(k + 1);
      cand_n[k]   = sp_phys[s_k[5:0]];
      cand_v_n[k] = a_hit && (k < PF_DEGREE) &&
                    (({1'b0, s_cur[3:0]} + 5'(k + 1)) <= 5'd15) &&
                    sp_valid[s_k[5:0]] && (sp_tag[s_k[5:0]] == s_k[15:6]);
    end
  end

  always_comb begin
    state_n  = state;
    emit     = 1'b0;
    emit_idx = 2'd0;
    case (state)
      IDLE: state_n = IDLE;
      WAIT: state_n = EMIT;
      EMIT: begin
        if (cand_v != 4'd0) begin
          emit = 1'b1;
          for (int k = 3; k >= 0; k--)
            if (cand_v[k]) emit_idx = 2'(k);
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    if (v_in) begin
      state_n = WAIT;
      emit    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // B's mapping is written before A's so an index collision leaves A's entry in place.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++)  tu_valid[i] <= 1'b0;
      for (int i = 0; i < 64; i++) begin
        ps_valid[i] <= 1'b0;
        sp_valid[i] <= 1'b0;
      end
      alloc   <= 16'h0000;
      cand_v  <= 4'd0;
      v_out   <= 1'b0;
      pf_addr <= 16'h0000;
    end else if (v_in) begin
      tu_valid[tu_idx] <= 1'b1;
      tu_tag[tu_idx]   <= pc[15:3];
      tu_last[tu_idx]  <= addr;
      if (train) begin
        alloc <= alloc_n;
        if (!b_hit) begin
          ps_valid[last_b[5:0]]  <= 1'b1;
          ps_tag[last_b[5:0]]    <= last_b[15:6];
          ps_struct[last_b[5:0]] <= alloc;
          sp_valid[alloc[5:0]]   <= 1'b1;
          sp_tag[alloc[5:0]]     <= alloc[15:6];
          sp_phys[alloc[5:0]]    <= last_b;
        end
        ps_valid[addr[5:0]]  <= 1'b1;
        ps_tag[addr[5:0]]    <= addr[15:6];
        ps_struct[addr[5:0]] <= s_a;
        sp_valid[s_a[5:0]]   <= 1'b1;
        sp_tag[s_a[5:0]]     <= s_a[15:6];
        sp_phys[s_a[5:0]]    <= addr;
      end
      cand    <= cand_n;
      cand_v  <= cand_v_n;
      v_out   <= 1'b0;
      pf_addr <= 16'h0000;
    end else if (emit) begin
      v_out            <= 1'b1;
      pf_addr          <= cand[emit_idx];
      cand_v[emit_idx] <= 1'b0;
    end else begin
      v_out   <= 1'b0;
      pf_addr <= 16'h0000;
    end
  end

endmodule

// File: tb/tb_isb_prefetcher.sv
// Scoreboard bench for isb_prefetcher: degree-1 and degree-3 instances share stimulus
// and are checked against a table-level reference model of the correlation rules.
module tb_isb_prefetcher;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        v_in = 1'b0;
  logic [15:0] pc = 16'h0000;
  logic [15:0] addr = 16'h0000;
  logic        v_out1, v_out3;
  logic [15:0] pf1, pf3;

  isb_prefetcher dut1 (
    .clk(clk), .reset(reset), .v_in(v_in), .pc(pc), .addr(addr),
    .v_out(v_out1), .pf_addr(pf1)
  );

  isb_prefetcher #(.PF_DEGREE(3)) dut3 (
    .clk(clk), .reset(reset), .v_in(v_in), .pc(pc), .addr(addr),
    .v_out(v_out3), .pf_addr(pf3)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int          at;
    logic [15:0] a;
  } pf_t;

  pf_t q1[$];
  pf_t q3[$];
  int  compared = 0;
  int  mismatched = 0;
  bit  mon_en = 1'b0;

  bit          m_tu_v   [8];
  logic [15:0] m_tu_pc  [8];
  logic [15:0] m_tu_last[8];
  bit          m_ps_v   [64];
  logic [15:0] m_ps_key [64];
  logic [15:0] m_ps_s   [64];
  bit          m_sp_v   [64];
  logic [15:0] m_sp_key [64];
  logic [15:0] m_sp_p   [64];
  logic [15:0] m_alloc;

  function automatic bit ps_lookup(input logic [15:0] a, output logic [15:0] s);
    int i = int'(a % 64);
    s = m_ps_s[i];
    return m_ps_v[i] && (m_ps_key[i] == a);
  endfunction

  function automatic bit sp_lookup(input logic [15:0] s, output logic [15:0] p);
    int i = int'(s % 64);
    p = m_sp_p[i];
    return m_sp_v[i] && (m_sp_key[i] == s);
  endfunction

  function automatic void map_pair(input logic [15:0] phys, input logic [15:0] st);
    m_ps_v[int'(phys % 64)]   = 1'b1;
    m_ps_key[int'(phys % 64)] = phys;
    m_ps_s[int'(phys % 64)]   = st;
    m_sp_v[int'(st % 64)]     = 1'b1;
    m_sp_key[int'(st % 64)]   = st;
    m_sp_p[int'(st % 64)]     = phys;
  endfunction

  function automatic void cancel_from(input int at);
    while (q1.size() > 0 && q1[q1.size()-1].at >= at) void'(q1.pop_back());
    while (q3.size() > 0 && q3[q3.size()-1].at >= at) void'(q3.pop_back());
  endfunction

  function automatic void model_reset(input int at);
    cancel_from(at);
    for (int i = 0; i < 8; i++) m_tu_v[i] = 1'b0;
    for (int i = 0; i < 64; i++) begin
      m_ps_v[i] = 1'b0;
      m_sp_v[i] = 1'b0;
    end
    m_alloc = 16'h0000;
  endfunction

  // Expected prefetches come from the pre-update maps; consecutive hits fill consecutive cycles.
  function automatic void model_access(input logic [15:0] p, input logic [15:0] a, input int at);
    logic [15:0] s, t, hitp, b, sb, sa;
    int slot, ti;
    cancel_from(at);
    if (ps_lookup(a, s)) begin
      for (int id = 0; id < 2; id++) begin
        slot = at + 2;
        for (int k = 1; k <= ((id == 0) ? 1 : 3); k++) begin
          t = s + 16'(k);
          if ((t / 16 == s / 16) && sp_lookup(t, hitp)) begin
            if (id == 0) q1.push_back('{slot, hitp});
            else         q3.push_back('{slot, hitp});
            slot++;
          end
        end
      end
    end
    ti = int'(p % 8);
    if (!(m_tu_v[ti] && (m_tu_pc[ti] / 8 == p / 8))) begin
      m_tu_v[ti]    = 1'b1;
      m_tu_pc[ti]   = p;
      m_tu_last[ti] = a;
    end else begin
      b = m_tu_last[ti];
      if (b != a) begin
        if (!ps_lookup(b, sb)) begin
          sb = m_alloc;
          m_alloc = m_alloc + 16'd16;
          map_pair(b, sb);
        end
        if (sb % 16 == 15) begin
          sa = m_alloc;
          m_alloc = m_alloc + 16'd16;
        end else begin
          sa = sb + 16'd1;
        end
        map_pair(a, sa);
      end
      m_tu_pc[ti]   = p;
      m_tu_last[ti] = a;
    end
  endfunction

  task automatic apply_stimulus(input bit v, input logic [15:0] p, input logic [15:0] a);
    @(negedge clk);
    v_in = v;
    pc   = p;
    addr = a;
    if (v) model_access(p, a, cyc + 1);
  endtask

  task automatic idle(input int n);
    repeat (n) apply_stimulus(1'b0, 16'($urandom), 16'($urandom));
  endtask

  task automatic do_reset(input int n);
    repeat (n) begin
      @(negedge clk);
      reset = 1'b1;
      v_in  = 1'b1;
      pc    = 16'($urandom);
      addr  = 16'($urandom);
      model_reset(cyc + 1);
    end
    @(negedge clk);
    reset  = 1'b0;
    v_in   = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic check_output(input int id, input bit v, input logic [15:0] a);
    pf_t exp;
    bit  has;
    has = (id == 0) ? (q1.size() > 0 && q1[0].at == cyc) : (q3.size() > 0 && q3[0].at == cyc);
    compared++;
    if (has) begin
      exp = (id == 0) ? q1.pop_front() : q3.pop_front();
      if (!v || a != exp.a) begin
        mismatched++;
        $display("[TB] FAIL prefetch_deg%0d cyc=%0d: got v_out=%0b pf_addr=%h, required v_out=1 pf_addr=%h",
                 (id == 0) ? 1 : 3, cyc, v, a, exp.a);
      end
    end else if (v || a != 16'h0000) begin
      mismatched++;
      $display("[TB] FAIL quiet_deg%0d cyc=%0d: got v_out=%0b pf_addr=%h, required v_out=0 pf_addr=0000",
               (id == 0) ? 1 : 3, cyc, v, a);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      check_output(0, v_out1, pf1);
      check_output(1, v_out3, pf3);
    end
  end

  initial begin
    logic [15:0] pcs [4];
    logic [15:0] seq_a, a;
    int sel;
    pcs[0] = 16'h0000; pcs[1] = 16'h0008; pcs[2] = 16'h1234; pcs[3] = 16'h00F1;
    seq_a = 16'h0200;

    do_reset(2);
    idle(2);

    for (int i = 0; i < 5; i++) apply_stimulus(1'b1, 16'h0000, 16'h0010 + 16'(i));
    idle(4);
    apply_stimulus(1'b1, 16'h1234, 16'h0010);
    idle(6);
    apply_stimulus(1'b1, 16'h2222, 16'h0011);
    idle(6);
    apply_stimulus(1'b1, 16'h3333, 16'h0013);
    apply_stimulus(1'b1, 16'h3333, 16'h0010);
    idle(6);

    do_reset(1);
    for (int i = 0; i < 17; i++) apply_stimulus(1'b1, 16'h0040, 16'h0100 + 16'(i));
    idle(3);
    apply_stimulus(1'b1, 16'h5555, 16'h010F);
    idle(5);
    apply_stimulus(1'b1, 16'h5555, 16'h010D);
    idle(5);

    do_reset(1);
    for (int i = 0; i < 8; i++)
      apply_stimulus(1'b1, (i % 2 == 1) ? 16'h0008 : 16'h0000, 16'h0300 + 16'(i));
    apply_stimulus(1'b1, 16'h7777, 16'h0300);
    idle(4);

    do_reset(1);
    for (int i = 0; i < 5; i++) apply_stimulus(1'b1, 16'h0000, 16'h0010 + 16'(i));
    idle(3);
    apply_stimulus(1'b1, 16'h2222, 16'h0011);
    idle(2);
    do_reset(1);
    apply_stimulus(1'b1, 16'h2222, 16'h0011);
    idle(5);

    for (int r = 0; r < 3; r++) begin
      do_reset(1);
      for (int i = 0; i < 400; i++) begin
        sel = $urandom_range(0, 99);
        if (sel < 2) begin
          do_reset(1);
        end else if (sel < 65) begin
          if ($urandom_range(0, 1) == 1) seq_a = seq_a + 16'd1;
          else                           seq_a = 16'h0200 + 16'($urandom_range(0, 63));
          a = ($urandom_range(0, 9) == 0) ? (seq_a ^ 16'h4000) : seq_a;
          apply_stimulus(1'b1, pcs[$urandom_range(0, 3)], a);
        end else begin
          idle(1);
        end
      end
    end

    idle(8);
    compared++;
    if (q1.size() + q3.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL drain: got %0d expected prefetches never emitted, required 0", q1.size() + q3.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/isb_prefetcher.md
ISB_PREFETCHER -- requirements
Module: isb_prefetcher

Interface
REQ-001 The block SHALL have one parameter: PF_DEGREE, default 1, number of successor prefetches per triggering access (legal 1..4).
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit, synchronous active-high reset.
REQ-004 The block SHALL have port v_in, input, 1 bit, a demand access is presented this cycle.
REQ-005 The block SHALL have port pc, input, 16 bits, PC of the demand access.
REQ-006 The block SHALL have port addr, input, 16 bits, physical line address of the demand access.
REQ-007 The block SHALL have port v_out, output, 1 bit, pf_addr is a valid prefetch request this cycle.
REQ-008 The block SHALL have port pf_addr, output, 16 bits, physical address to prefetch.

Function
REQ-009 The block SHALL accept one access per cycle when v_in=1, with no backpressure; pc/addr are don't-care when v_in=0.
REQ-010 The training unit (TU) SHALL be 8 entries, direct-mapped by pc[2:0], tag pc[15:3], holding valid and last_addr.
REQ-011 The PS map SHALL be 64 entries, direct-mapped by addr[5:0], tag addr[15:6], holding valid and a 16-bit structural address.
REQ-012 The SP map SHALL be 64 entries, direct-mapped by struct[5:0], tag struct[15:6], holding valid and a 16-bit physical address.
REQ-013 A 16-bit chunk allocator SHALL start at 0x0000 and advance by 16 per allocation, wrapping modulo 2^16.
REQ-014 On TU miss (invalid or tag mismatch), the block SHALL install {tag, last_addr=addr} and perform no correlation training.
REQ-015 On TU hit with last_addr B: if B has no PS mapping, the block SHALL allocate a chunk and map B to its base (PS[B], SP[base]).
REQ-016 On TU hit, with s_B = PS[B] structural, the block SHALL set s_A = s_B+1, or a freshly allocated chunk base if s_B[3:0]=4'hF.
REQ-017 The block SHALL write PS[addr]=s_A and SP[s_A]=addr, overwriting any prior entry at those indices, then set TU last_addr=addr.
REQ-018 If B==addr (repeat access), the block SHALL perform no correlation write; TU last_addr stays addr.
REQ-019 Prediction SHALL use the PS/SP state before the same access's training writes.
REQ-020 If PS[addr] hits with structural s, the block SHALL emit SP[s+k] for k=1..PF_DEGREE in order, one per cycle, skipping SP misses.
REQ-021 The first candidate SHALL appear on v_out/pf_addr exactly 2 cycles after the access edge (access sampled at edge N; output valid after edge N+2).
REQ-022 A new accepted access SHALL cancel any remaining candidates of the previous access.
REQ-023 When v_out=0, pf_addr SHALL hold 16'h0000.
REQ-024 Table updates for an access SHALL be visible to an access presented on the next cycle (back-to-back forwarding required).

Reset
REQ-025 While reset=1 at a clock edge, the block SHALL clear all TU, PS and SP valid bits, set the allocator to 0x0000, cancel pending candidates and drive v_out=0, pf_addr=0.
REQ-026 An access presented with reset=1 SHALL be discarded; reset SHALL take priority over mid-sequence prefetch emission.
REQ-027 The first access after reset deassertion SHALL be processed normally.

Verification
REQ-028 Reset, then PC 0x0000 accesses 0x0010..0x0014 on consecutive cycles -> PS maps 0x0010..0x0014 to 0x0000..0x0004; allocator 0x0010.
REQ-029 After REQ-028, access 0x0010 (any PC) -> v_out=1, pf_addr=0x0011 two cycles later, then v_out=0 (PF_DEGREE=1).
REQ-030 PF_DEGREE=3, same training, access 0x0011 -> pf_addr 0x0012, 0x0013, 0x0014 on three consecutive cycles starting 2 cycles later.
REQ-031 Train 17 sequential addresses 0x0100..0x0110 on one PC -> 0x0110 maps to 0x0010 (second chunk); access 0x010F produces no prefetch.
REQ-032 Accesses from PC 0x0000 and PC 0x0008 interleaved -> each TU miss replaces the other; no PS/SP writes, no prefetches.
REQ-033 Assert reset during a PF_DEGREE=3 emission -> v_out=0 the next cycle; replaying a trained address then yields no prefetch.
